// File: rtl/status_register_unit_pkg.sv
// ----------------------------------------------------------------------------
// status_register_unit_pkg
// Shared constants for the status-register slice of the pipeline.
//   - ALU command encodings seen by the EXE stage.
//   - Bit positions of the N/Z/C/V flags inside the 4-bit status register.
//   - A helper that tells whether a command produces a real carry/overflow.
// The condition-check stage imports this same package, so flag positions
// and command codes cannot drift between the writer and the reader.
// ----------------------------------------------------------------------------
package status_register_unit_pkg;

    // ALU command encodings
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    // Flag bit positions inside SR ({N,Z,C,V})
    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;

    // Only the add/subtract family produces a meaningful carry and overflow;
    // every other command leaves C and V as they were.
    function automatic logic isArithCmd(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_ADC) ||
               (cmd == CMD_SUB) || (cmd == CMD_SBC);
    endfunction

endpackage

// File: rtl/status_register_unit_flag_gen.sv
// ----------------------------------------------------------------------------
// flag_gen
// Purely combinational next-flag calculation for the status register.
// Ports:
//   i_aluCmd     ALU command of the EXE-stage instruction
//   i_aluResult  ALU result (WIDTH bits)
//   i_aluCout    ALU carry-out (NOT borrow for SUB/SBC)
//   i_aluOvf     ALU signed overflow
//   i_curC       current C flag, kept for non-arithmetic commands
//   i_curV       current V flag, kept for non-arithmetic commands
//   o_flags      candidate flags {N,Z,C,V}
// ----------------------------------------------------------------------------
module flag_gen
    import status_register_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_aluCmd,
    input  logic [WIDTH-1:0] i_aluResult,
    input  logic             i_aluCout,
    input  logic             i_aluOvf,
    input  logic             i_curC,
    input  logic             i_curV,
    output logic [3:0]       o_flags
);

    // N and Z always come from the result. C and V come from the ALU only
    // for add/subtract; logical and move commands leave them as they were.
    always_comb begin
        o_flags       = 4'b0000;
        o_flags[SR_N] = i_aluResult[WIDTH-1];
        o_flags[SR_Z] = (i_aluResult == '0);
        if (isArithCmd(i_aluCmd)) begin
            o_flags[SR_C] = i_aluCout;
            o_flags[SR_V] = i_aluOvf;
        end else begin
            o_flags[SR_C] = i_curC;
            o_flags[SR_V] = i_curV;
        end
    end

endmodule

// File: rtl/status_register_unit.sv
// ----------------------------------------------------------------------------
// status_register_unit
// Holds the N/Z/C/V status register written by flag-setting instructions in
// the EXE stage, offers a zero-latency forwarded copy, and counts commits.
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           asynchronous active-high reset
//   freeze        pipeline stall; no state changes while high
//   valid         EXE instruction is real (not a bubble)
//   S             instruction's set-flags bit
//   alu_cmd       ALU command
//   alu_result    ALU result
//   alu_cout      ALU carry-out (NOT borrow on subtract)
//   alu_ovf       ALU signed overflow
//   SR            registered flags {N,Z,C,V}
//   SR_fwd        next flag value this cycle (equals SR when nothing writes)
//   flag_pending  a flag write commits at the coming edge
//   wr_count      saturating count of committed flag writes
// ----------------------------------------------------------------------------
module status_register_unit
    import status_register_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             valid,
    input  logic             S,
    input  logic [3:0]       alu_cmd,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    input  logic             alu_ovf,
    output logic [3:0]       SR,
    output logic [3:0]       SR_fwd,
    output logic             flag_pending,
    output logic [CNT_W-1:0] wr_count
);

    logic [3:0]       r_sr;
    logic [CNT_W-1:0] r_wrCount;
    logic [3:0]       w_newFlags;
    logic             w_wrEn;

    flag_gen #(
        .WIDTH (WIDTH)
    ) u_flagGen (
        .i_aluCmd    (alu_cmd),
        .i_aluResult (alu_result),
        .i_aluCout   (alu_cout),
        .i_aluOvf    (alu_ovf),
        .i_curC      (r_sr[SR_C]),
        .i_curV      (r_sr[SR_V]),
        .o_flags     (w_newFlags)
    );

    // A write happens only for a real, flag-setting instruction that is not
    // stalled; bubbles and flushed slots never touch the flags.
    assign w_wrEn = valid & S & ~freeze;

    // Forwarded flags let the next instruction see this cycle's result
    // without waiting for the register.
    assign SR_fwd       = w_wrEn ? w_newFlags : r_sr;
    assign flag_pending = w_wrEn;
    assign SR           = r_sr;
    assign wr_count     = r_wrCount;

    // Status register and commit counter. The counter sticks at all-ones so
    // a long run never looks like "few writes" after a wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr      <= 4'b0000;
            r_wrCount <= '0;
        end else if (w_wrEn) begin
            r_sr <= w_newFlags;
            if (r_wrCount != {CNT_W{1'b1}}) begin
                r_wrCount <= r_wrCount + 1'b1;
            end
        end
    end

endmodule
